// File: rtl/duty_button_debouncer_pkg.sv
// rtl/duty_button_debouncer_pkg.sv - shared types and helpers for the duty button debouncer
//
// Purpose : channel state encoding and debounce counter width helper.
// Ports   : none (package).

package duty_button_debouncer_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESSED = 1'b1
   } chan_state_t;

   // Width of a counter that must hold values 0..cycles.
   function automatic int cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/duty_button_debouncer_channel.sv
// rtl/duty_button_debouncer_channel.sv - one button channel: synchronizer, debounce FSM, accept strobe
//
// Purpose : turns an asynchronous bouncy button level into a single-cycle
//           accept strobe per debounced press; releases are debounced too
//           but produce no strobe.
// Ports   : clk      - rising-edge clock
//           rst_n    - synchronous active-low reset
//           btn_raw  - asynchronous raw button level, active-high
//           accept   - combinational strobe, high in the cycle the press is
//                      accepted (registered by the parent)

module debounce_channel
   import duty_button_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic accept
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic        sync_meta;
   logic        sync;
   chan_state_t state;
   chan_state_t state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         state     <= ST_IDLE;
         cnt       <= '0;
      end else begin
         sync_meta <= btn_raw;
         sync      <= sync_meta;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
      end
   end

   // The counter always counts samples that disagree with the current state;
   // any agreeing sample restarts the run.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sync) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = ST_PRESSED;
                  cnt_nxt   = '0;
                  accept    = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         ST_PRESSED: begin
            if (!sync) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/duty_button_debouncer.sv
// rtl/duty_button_debouncer.sv - debounced increase/decrease duty buttons with conflict arbitration
//
// Purpose : two debounce channels feeding registered single-cycle pulses
//           for a PWM generator; simultaneous accepts cancel each other and
//           are reported as a conflict instead.
// Ports   : clk           - rising-edge clock
//           rst_n         - synchronous active-low reset
//           inc_btn_raw   - raw increase button, async, active-high
//           dec_btn_raw   - raw decrease button, async, active-high
//           increase_duty - one-cycle pulse per accepted increase press
//           decrease_duty - one-cycle pulse per accepted decrease press
//           conflict      - one-cycle pulse when both accepts coincide

module duty_button_debouncer
   import duty_button_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_btn_raw,
   input  logic dec_btn_raw,
   output logic increase_duty,
   output logic decrease_duty,
   output logic conflict
);

   logic inc_accept;
   logic dec_accept;

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_inc_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (inc_btn_raw),
      .accept  (inc_accept)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_dec_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (dec_btn_raw),
      .accept  (dec_accept)
   );

   // Outputs are mutually exclusive by construction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         increase_duty <= 1'b0;
         decrease_duty <= 1'b0;
         conflict      <= 1'b0;
      end else begin
         increase_duty <= inc_accept & ~dec_accept;
         decrease_duty <= dec_accept & ~inc_accept;
         conflict      <= inc_accept & dec_accept;
      end
   end

endmodule

// File: tb/tb_duty_button_debouncer.sv
// tb/tb_duty_button_debouncer.sv - directed self-checking bench for duty_button_debouncer

module tb_duty_button_debouncer;

   logic clk = 1'b0;
   logic rst_n;
   logic inc_btn_raw;
   logic dec_btn_raw;
   logic increase_duty;
   logic decrease_duty;
   logic conflict;

   int vec_cnt = 0;
   int err_cnt = 0;

   int cyc = 0;
   int inc_cnt = 0, dec_cnt = 0, conf_cnt = 0;
   int inc_last = -1, dec_last = -1, conf_last = -1;
   int wide = 0, multi = 0;
   logic inc_prev = 1'b0, dec_prev = 1'b0, conf_prev = 1'b0;
   int t0, t1;

   always #5 clk = ~clk;

   duty_button_debouncer #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .inc_btn_raw   (inc_btn_raw),
      .dec_btn_raw   (dec_btn_raw),
      .increase_duty (increase_duty),
      .decrease_duty (decrease_duty),
      .conflict      (conflict)
   );

   // Pulse monitor: cyc = number of rising edges seen so far.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (increase_duty === 1'b1) begin
         inc_cnt++;
         inc_last = cyc;
         if (inc_prev) wide++;
      end
      if (decrease_duty === 1'b1) begin
         dec_cnt++;
         dec_last = cyc;
         if (dec_prev) wide++;
      end
      if (conflict === 1'b1) begin
         conf_cnt++;
         conf_last = cyc;
         if (conf_prev) wide++;
      end
      if ((int'(increase_duty === 1'b1) + int'(decrease_duty === 1'b1) + int'(conflict === 1'b1)) > 1)
         multi++;
      inc_prev  = (increase_duty === 1'b1);
      dec_prev  = (decrease_duty === 1'b1);
      conf_prev = (conflict === 1'b1);
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic i, input logic d, input int n);
      inc_btn_raw = i;
      dec_btn_raw = d;
      cycles(n);
   endtask

   task automatic clr_counts();
      inc_cnt = 0; dec_cnt = 0; conf_cnt = 0;
      inc_last = -1; dec_last = -1; conf_last = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b0;
      inc_btn_raw = 1'b0;
      dec_btn_raw = 1'b0;
      cycles(3);
      check_val("rst_inc", int'(increase_duty), 0);
      check_val("rst_dec", int'(decrease_duty), 0);
      check_val("rst_conf", int'(conflict), 0);
      rst_n = 1'b1;
      cycles(3);

      // single increase press, 10 cycles
      clr_counts(); t0 = cyc;
      drive(1, 0, 10);
      check_val("t1_inc_cnt", inc_cnt, 1);
      check_val("t1_inc_lat", inc_last - t0, 6);
      check_val("t1_dec_cnt", dec_cnt, 0);
      check_val("t1_conf_cnt", conf_cnt, 0);
      drive(0, 0, 10);
      check_val("t1_no_release_pulse", inc_cnt, 1);

      // glitch of 3 cycles rejected, 4 cycles accepted
      clr_counts();
      drive(1, 0, 3);
      drive(0, 0, 10);
      check_val("glitch3_inc_cnt", inc_cnt, 0);
      clr_counts(); t0 = cyc;
      drive(1, 0, 4);
      drive(0, 0, 10);
      check_val("glitch4_inc_cnt", inc_cnt, 1);
      check_val("glitch4_inc_lat", inc_last - t0, 6);

      // bouncy decrease press then steady
      clr_counts();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 1);
         drive(0, 0, 1);
      end
      t0 = cyc;
      drive(0, 1, 10);
      check_val("t2_dec_cnt", dec_cnt, 1);
      check_val("t2_dec_lat", dec_last - t0, 6);
      check_val("t2_inc_cnt", inc_cnt, 0);
      drive(0, 0, 10);

      // dropout during press, then a second press
      clr_counts(); t0 = cyc;
      drive(1, 0, 5);
      drive(0, 0, 2);
      drive(1, 0, 3);
      check_val("t3_first_cnt", inc_cnt, 1);
      check_val("t3_first_lat", inc_last - t0, 6);
      drive(0, 0, 10);
      check_val("t3_after_dropout", inc_cnt, 1);
      t1 = cyc;
      drive(1, 0, 10);
      check_val("t3_second_cnt", inc_cnt, 2);
      check_val("t3_second_lat", inc_last - t1, 6);
      drive(0, 0, 10);

      // simultaneous presses
      clr_counts(); t0 = cyc;
      drive(1, 1, 10);
      check_val("t4_conf_cnt", conf_cnt, 1);
      check_val("t4_conf_lat", conf_last - t0, 6);
      check_val("t4_inc_cnt", inc_cnt, 0);
      check_val("t4_dec_cnt", dec_cnt, 0);
      drive(0, 0, 10);
      check_val("t4_no_late_pulse", inc_cnt + dec_cnt + conf_cnt, 1);

      // presses one cycle apart: adjacent independent pulses
      clr_counts(); t0 = cyc;
      drive(1, 0, 1);
      drive(1, 1, 10);
      check_val("adj_inc_lat", inc_last - t0, 6);
      check_val("adj_dec_lat", dec_last - t0, 7);
      check_val("adj_conf_cnt", conf_cnt, 0);
      drive(0, 0, 10);

      // reset mid-press with counter at 2
      clr_counts();
      drive(1, 0, 4);
      rst_n = 1'b0;
      cycles(2);
      check_val("rst_mid_no_pulse", inc_cnt, 0);
      check_val("rst_mid_out_low", int'(increase_duty), 0);
      rst_n = 1'b1;
      t1 = cyc;
      cycles(10);
      check_val("rst_mid_cnt", inc_cnt, 1);
      check_val("rst_mid_lat", inc_last - t1, 6);
      drive(0, 0, 10);

      // three press/release cycles on each button
      clr_counts();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 10);
         drive(0, 0, 10);
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 10);
         drive(0, 0, 10);
      end
      check_val("t6_inc_cnt", inc_cnt, 3);
      check_val("t6_dec_cnt", dec_cnt, 3);
      check_val("t6_conf_cnt", conf_cnt, 0);

      check_val("pulse_width_one", wide, 0);
      check_val("outputs_exclusive", multi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/duty_button_debouncer.md
DUTY_BUTTON_DEBOUNCER -- requirements
Module: duty_button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a press or release; legal range 2..65535.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 inc_btn_raw  input  1  asynchronous, bouncy "increase" button level, active-high.
REQ-005 dec_btn_raw  input  1  asynchronous, bouncy "decrease" button level, active-high.
REQ-006 increase_duty  output  1  one-cycle pulse per accepted increase press; drives the PWM generator's increase_duty input.
REQ-007 decrease_duty  output  1  one-cycle pulse per accepted decrease press; drives the PWM generator's decrease_duty input.
REQ-008 conflict  output  1  one-cycle pulse when both presses are accepted in the same cycle.

Function
REQ-009 Each raw input shall pass through a 2-flop synchronizer; all later logic uses only the second flop (sync).
REQ-010 Each channel shall run FSM IDLE -> PRESSED -> IDLE with one counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-011 IDLE: counter increments on each cycle with sync=1; it clears on any cycle with sync=0.
REQ-012 IDLE: on the cycle sync=1 and counter=DEBOUNCE_CYCLES-1, the channel shall go to PRESSED, clear the counter and raise an internal accept strobe, registered to the output on the next edge.
REQ-013 PRESSED: counter increments on each cycle with sync=0 and clears on sync=1; at DEBOUNCE_CYCLES consecutive lows the channel returns to IDLE with the counter cleared; no strobe is produced on release.
REQ-014 Latency: raw held high from edge N (sampled at N) -> output pulse high for exactly the one cycle following edge N+1+DEBOUNCE_CYCLES.
REQ-015 A high glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no pulse; a low bounce shorter than DEBOUNCE_CYCLES during PRESSED shall not re-arm and shall produce no second pulse.
REQ-016 Holding a button indefinitely shall produce exactly one pulse (no auto-repeat).
REQ-017 If only one channel strobes in a cycle, only its output pulses; the other output stays 0.
REQ-018 If both channels strobe in the same cycle, increase_duty and decrease_duty shall both stay 0 and conflict shall pulse 1 cycle; both channels still enter PRESSED.
REQ-019 Strobes of the two channels in different cycles are independent; they may occur in adjacent cycles.
REQ-020 Outputs shall be registered; at most one of increase_duty, decrease_duty, conflict is 1 in any cycle.

Reset
REQ-021 When rst_n=0 at a clk edge: synchronizer flops, counters = 0; FSMs = IDLE; increase_duty = decrease_duty = conflict = 0.
REQ-022 Reset mid-press aborts any count; a button still held after reset release shall give exactly one pulse after a full REQ-014 latency measured from the first edge with rst_n=1.

Structure
REQ-023 Shared package shall hold the channel state enum (IDLE, PRESSED) and a counter-width function/constant derived from DEBOUNCE_CYCLES.
REQ-024 Sub-module debounce_channel (synchronizer, FSM, counter, accept strobe) shall be instantiated twice; top holds only the conflict arbitration and output registers.

Verification (clk period 10 ns, DEBOUNCE_CYCLES=4)
REQ-025 inc_btn_raw high 100 ns from edge 0 -> increase_duty high exactly during cycle after edge 5, once; decrease_duty and conflict stay 0.
REQ-026 dec_btn_raw toggling 1/0 every 10 ns for 60 ns, then steady 1 for 100 ns -> exactly one decrease_duty pulse, 6 cycles after the steady-high start edge (edge N+1+DEBOUNCE_CYCLES).
REQ-027 inc_btn_raw high 100 ns with 2-cycle low dropout at 50 ns -> one pulse only; release 100 ns then press again -> second pulse.
REQ-028 Both raw inputs rise at the same edge, held 100 ns -> conflict one pulse, increase_duty and decrease_duty never 1.
REQ-029 rst_n low for 2 cycles while inc_btn_raw held and counter=2 -> no pulse during reset; one pulse 6 cycles after reset release.
REQ-030 Three press/release cycles on each button (100 ns each) -> exactly 3 increase_duty and 3 decrease_duty pulses, each 1 cycle wide.
